ex_operand_stage: RTL and testbench

ID/EX pipeline register with operand forwarding and load-use hazard detection for the RV32I core. Latches decoded instruction fields from ID and produces the final ALU operands: A/B to the ALU and its compare units (set_less_than, branch compare), plus rs2 store data. Resolves RAW hazards by forwarding from MEM and WB. Requests a one-cycle upstream stall for load-use dependencies.

---
 rtl/ex_operand_stage.sv | 140 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register for the RV32I core: captures decoded ID fields, forwards
// MEM/WB results into the ALU operands and requests a one-cycle stall on load-use.
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [3:0]        id_alu_op_i,
  input  logic              id_bsel_i,
  input  logic              id_asel_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic              id_rd_wren_i,
  input  logic              id_mem_rden_i,
  input  logic              id_mem_wren_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic              mem_rd_wren_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic              wb_rd_wren_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [XLEN-1:0]   ex_op_a_o,
  output logic [XLEN-1:0]   ex_op_b_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [3:0]        ex_alu_op_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic              ex_rd_wren_o,
  output logic              ex_mem_rden_o,
  output logic              ex_mem_wren_o
);

  logic              ex_valid_reg;
  logic [XLEN-1:0]   ex_pc_reg;
  logic [XLEN-1:0]   ex_imm_reg;
  logic [REG_AW-1:0] ex_rs1_addr_reg;
  logic [REG_AW-1:0] ex_rs2_addr_reg;
  logic [XLEN-1:0]   ex_rs1_data_reg;
  logic [XLEN-1:0]   ex_rs2_data_reg;
  logic [3:0]        ex_alu_op_reg;
  logic              ex_bsel_reg;
  logic              ex_asel_reg;
  logic [REG_AW-1:0] ex_rd_addr_reg;
  logic              ex_rd_wren_reg;
  logic              ex_mem_rden_reg;
  logic              ex_mem_wren_reg;

  logic load_use;

  // Both sources are compared even if the operand mux will not select them.
  assign load_use = ex_valid_reg & ex_mem_rden_reg & (ex_rd_addr_reg != '0) & id_valid_i &
                    ((id_rs1_addr_i == ex_rd_addr_reg) | (id_rs2_addr_i == ex_rd_addr_reg));

  assign stall_o = (load_use & ~flush_i) | hold_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_reg    <= 1'b0;
      ex_pc_reg       <= '0;
      ex_imm_reg      <= '0;
      ex_rs1_addr_reg <= '0;
      ex_rs2_addr_reg <= '0;
      ex_rs1_data_reg <= '0;
      ex_rs2_data_reg <= '0;
      ex_alu_op_reg   <= '0;
      ex_bsel_reg     <= 1'b0;
      ex_asel_reg     <= 1'b0;
      ex_rd_addr_reg  <= '0;
      ex_rd_wren_reg  <= 1'b0;
      ex_mem_rden_reg <= 1'b0;
      ex_mem_wren_reg <= 1'b0;
    end else if (hold_i) begin
      ex_valid_reg <= ex_valid_reg;
    end else if (flush_i || load_use) begin
      // Bubble: only validity and side-effecting enables matter.
      ex_valid_reg    <= 1'b0;
      ex_rd_wren_reg  <= 1'b0;
      ex_mem_rden_reg <= 1'b0;
      ex_mem_wren_reg <= 1'b0;
    end else begin
      ex_valid_reg    <= id_valid_i;
      ex_pc_reg       <= id_pc_i;
      ex_imm_reg      <= id_imm_i;
      ex_rs1_addr_reg <= id_rs1_addr_i;
      ex_rs2_addr_reg <= id_rs2_addr_i;
      ex_rs1_data_reg <= id_rs1_data_i;
      ex_rs2_data_reg <= id_rs2_data_i;
      ex_alu_op_reg   <= id_alu_op_i;
      ex_bsel_reg     <= id_bsel_i;
      ex_asel_reg     <= id_asel_i;
      ex_rd_addr_reg  <= id_rd_addr_i;
      ex_rd_wren_reg  <= id_rd_wren_i & id_valid_i;
      ex_mem_rden_reg <= id_mem_rden_i & id_valid_i;
      ex_mem_wren_reg <= id_mem_wren_i & id_valid_i;
    end
  end

  logic [REG_AW-1:0] src_addr [2];
  logic [XLEN-1:0]   src_data [2];
  logic [XLEN-1:0]   fwd_data [2];

  assign src_addr[0] = ex_rs1_addr_reg;
  assign src_addr[1] = ex_rs2_addr_reg;
  assign src_data[0] = ex_rs1_data_reg;
  assign src_data[1] = ex_rs2_data_reg;

  // MEM is younger than WB, so it wins; x0 always reads the register file value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_data[gi] =
      ((src_addr[gi] != '0) && mem_rd_wren_i && (mem_rd_addr_i == src_addr[gi])) ? mem_data_i :
      ((src_addr[gi] != '0) && wb_rd_wren_i  && (wb_rd_addr_i  == src_addr[gi])) ? wb_data_i  :
      src_data[gi];
  end

  assign ex_op_a_o     = ex_asel_reg ? ex_pc_reg  : fwd_data[0];
  assign ex_op_b_o     = ex_bsel_reg ? ex_imm_reg : fwd_data[1];
  assign ex_rs2_data_o = fwd_data[1];

  assign ex_valid_o    = ex_valid_reg;
  assign ex_pc_o       = ex_pc_reg;
  assign ex_imm_o      = ex_imm_reg;
  assign ex_alu_op_o   = ex_alu_op_reg;
  assign ex_rd_addr_o  = ex_rd_addr_reg;
  assign ex_rd_wren_o  = ex_rd_wren_reg;
  assign ex_mem_rden_o = ex_mem_rden_reg;
  assign ex_mem_wren_o = ex_mem_wren_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: queued expectations for the EX register,
// inline checks for the combinational operands and stall.
module tb_ex_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        id_valid_i = 1'b0;
  logic [31:0] id_pc_i = '0;
  logic [4:0]  id_rs1_addr_i = '0, id_rs2_addr_i = '0;
  logic [31:0] id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0;
  logic [3:0]  id_alu_op_i = '0;
  logic        id_bsel_i = 1'b0, id_asel_i = 1'b0;
  logic [4:0]  id_rd_addr_i = '0;
  logic        id_rd_wren_i = 1'b0, id_mem_rden_i = 1'b0, id_mem_wren_i = 1'b0;
  logic [4:0]  mem_rd_addr_i = '0;
  logic        mem_rd_wren_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic [4:0]  wb_rd_addr_i = '0;
  logic        wb_rd_wren_i = 1'b0;
  logic [31:0] wb_data_i = '0;
  logic        flush_i = 1'b0, hold_i = 1'b0;
  logic        stall_o, ex_valid_o;
  logic [31:0] ex_pc_o, ex_imm_o, ex_op_a_o, ex_op_b_o, ex_rs2_data_o;
  logic [3:0]  ex_alu_op_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_rd_wren_o, ex_mem_rden_o, ex_mem_wren_o;

  ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_alu_op_i(id_alu_op_i),
    .id_bsel_i(id_bsel_i), .id_asel_i(id_asel_i),
    .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i),
    .id_mem_rden_i(id_mem_rden_i), .id_mem_wren_i(id_mem_wren_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_wren_i(mem_rd_wren_i), .mem_data_i(mem_data_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wren_i(wb_rd_wren_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o),
    .ex_op_a_o(ex_op_a_o), .ex_op_b_o(ex_op_b_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_alu_op_o(ex_alu_op_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_rd_wren_o(ex_rd_wren_o), .ex_mem_rden_o(ex_mem_rden_o), .ex_mem_wren_o(ex_mem_wren_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        full;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wren;
    logic        rden;
    logic        mwren;
  } ex_exp_t;

  ex_exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
    $display("check %-12s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [3:0] op, input logic bsel,
                          input logic asel, input logic [4:0] rd, input logic wren,
                          input logic rden, input logic mwren);
    id_valid_i = v; id_pc_i = pc; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
    id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm; id_alu_op_i = op;
    id_bsel_i = bsel; id_asel_i = asel; id_rd_addr_i = rd;
    id_rd_wren_i = wren; id_mem_rden_i = rden; id_mem_wren_i = mwren;
  endtask

  task automatic push_exp(input logic full, input logic valid, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [3:0] op, input logic [4:0] rd,
                          input logic wren, input logic rden, input logic mwren);
    ex_exp_t e;
    e.full = full; e.valid = valid; e.pc = pc; e.imm = imm; e.op = op; e.rd = rd;
    e.wren = wren; e.rden = rden; e.mwren = mwren;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    ex_exp_t e;
    vectors++;
    assert (exp_q.size() != 0) else begin
      miscompares++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(ex_valid_o), 32'(e.valid));
      check({tag, "_wren"},  32'(ex_rd_wren_o), 32'(e.wren));
      check({tag, "_rden"},  32'(ex_mem_rden_o), 32'(e.rden));
      check({tag, "_mwren"}, 32'(ex_mem_wren_o), 32'(e.mwren));
      if (e.full) begin
        check({tag, "_pc"},  ex_pc_o, e.pc);
        check({tag, "_imm"}, ex_imm_o, e.imm);
        check({tag, "_op"},  32'(ex_alu_op_o), 32'(e.op));
        check({tag, "_rd"},  32'(ex_rd_addr_o), 32'(e.rd));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(ex_valid_o), 32'h0);
    check({tag, "_pc"},    ex_pc_o, 32'h0);
    check({tag, "_imm"},   ex_imm_o, 32'h0);
    check({tag, "_opa"},   ex_op_a_o, 32'h0);
    check({tag, "_opb"},   ex_op_b_o, 32'h0);
    check({tag, "_rs2"},   ex_rs2_data_o, 32'h0);
    check({tag, "_aluop"}, 32'(ex_alu_op_o), 32'h0);
    check({tag, "_rd"},    32'(ex_rd_addr_o), 32'h0);
    check({tag, "_wren"},  32'(ex_rd_wren_o), 32'h0);
    check({tag, "_rden"},  32'(ex_mem_rden_o), 32'h0);
    check({tag, "_mwren"}, 32'(ex_mem_wren_o), 32'h0);
    check({tag, "_stall"}, 32'(stall_o), 32'h0);
  endtask

  initial begin
    // Power-on reset
    #3;
    check_all_zero("por");
    #3 rst_ni = 1'b1;

    // ADD x5,x1,x2 then SUB x6,x5,x7 with MEM and WB both targeting x5
    drive_id(1, 32'h100, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 4'd0, 0, 0, 5'd5, 1, 0, 0);
    push_exp(1, 1, 32'h100, 32'h0, 4'd0, 5'd5, 1, 0, 0);
    tick();
    pop_check("add");
    drive_id(1, 32'h104, 5'd5, 5'd7, 32'hAAAA, 32'h77, 32'h0, 4'd1, 0, 0, 5'd6, 1, 0, 0);
    #1;
    check("add_opa", ex_op_a_o, 32'h11);
    check("add_opb", ex_op_b_o, 32'h22);
    check("add_stall", 32'(stall_o), 32'h0);
    push_exp(1, 1, 32'h104, 32'h0, 4'd1, 5'd6, 1, 0, 0);
    tick();
    pop_check("sub");
    mem_rd_addr_i = 5'd5; mem_rd_wren_i = 1; mem_data_i = 32'h10;
    wb_rd_addr_i = 5'd5;  wb_rd_wren_i = 1;  wb_data_i = 32'h20;
    #1;
    check("sub_opa_mem", ex_op_a_o, 32'h10);
    check("sub_opb", ex_op_b_o, 32'h77);
    check("sub_rs2", ex_rs2_data_o, 32'h77);
    mem_rd_wren_i = 0;
    #1;
    check("sub_opa_wb", ex_op_a_o, 32'h20);
    wb_rd_wren_i = 0;

    // LW x3,4(x8) then SLT x4,x3,x2: one bubble, then WB forwarding
    drive_id(1, 32'h108, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4, 4'd0, 1, 0, 5'd3, 1, 1, 0);
    push_exp(1, 1, 32'h108, 32'h4, 4'd0, 5'd3, 1, 1, 0);
    tick();
    pop_check("lw");
    drive_id(1, 32'h10C, 5'd3, 5'd2, 32'h5, 32'h7, 32'h0, 4'd2, 0, 0, 5'd4, 1, 0, 0);
    #1;
    check("lw_opa", ex_op_a_o, 32'h1000);
    check("lw_opb_imm", ex_op_b_o, 32'h4);
    check("lu_stall", 32'(stall_o), 32'h1);
    push_exp(0, 0, 32'h0, 32'h0, 4'd0, 5'd0, 0, 0, 0);
    tick();
    pop_check("lu_bubble");
    check("lu_stall_drop", 32'(stall_o), 32'h0);
    push_exp(1, 1, 32'h10C, 32'h0, 4'd2, 5'd4, 1, 0, 0);
    wb_rd_addr_i = 5'd3; wb_rd_wren_i = 1; wb_data_i = 32'hFFFF_FFFF;
    tick();
    pop_check("slt");
    check("slt_opa", ex_op_a_o, 32'hFFFF_FFFF);
    check("slt_opb", ex_op_b_o, 32'h7);
    wb_rd_wren_i = 0;

    // x0 source never forwarded
    drive_id(1, 32'h110, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 0, 0, 5'd1, 1, 0, 0);
    push_exp(1, 1, 32'h110, 32'h0, 4'd0, 5'd1, 1, 0, 0);
    tick();
    pop_check("x0");
    mem_rd_addr_i = 5'd0; mem_rd_wren_i = 1; mem_data_i = 32'hDEAD_BEEF;
    wb_rd_addr_i = 5'd0;  wb_rd_wren_i = 1;  wb_data_i = 32'h1234_5678;
    #1;
    check("x0_opa", ex_op_a_o, 32'h0);
    check("x0_rs2", ex_rs2_data_o, 32'h0);
    mem_rd_wren_i = 0; wb_rd_wren_i = 0;

    // flush coincident with load-use hazard
    drive_id(1, 32'h114, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 4'd0, 1, 0, 5'd9, 1, 1, 0);
    push_exp(1, 1, 32'h114, 32'h8, 4'd0, 5'd9, 1, 1, 0);
    tick();
    pop_check("lw9");
    drive_id(1, 32'h118, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 1, 0, 5'd2, 1, 0, 1);
    flush_i = 1;
    #1;
    check("flush_stall", 32'(stall_o), 32'h0);
    push_exp(0, 0, 32'h0, 32'h0, 4'd0, 5'd0, 0, 0, 0);
    tick();
    pop_check("flush");
    flush_i = 0;

    // hold for 3 cycles while ID and forwarding inputs change
    drive_id(1, 32'h200, 5'd11, 5'd12, 32'hAA, 32'hBB, 32'h20, 4'd3, 0, 0, 5'd10, 1, 0, 0);
    push_exp(1, 1, 32'h200, 32'h20, 4'd3, 5'd10, 1, 0, 0);
    tick();
    pop_check("pre_hold");
    hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1, 32'h300 + 32'(i), 5'($urandom_range(1, 31)), 5'd0, $urandom, $urandom,
               $urandom, 4'($urandom), 0, 0, 5'd20, 1, 0, 1);
      flush_i = (i == 1);
      mem_rd_addr_i = 5'd11; mem_rd_wren_i = 1; mem_data_i = 32'h1000 + 32'(i);
      #1;
      check($sformatf("hold%0d_stall", i), 32'(stall_o), 32'h1);
      check($sformatf("hold%0d_opa", i), ex_op_a_o, 32'h1000 + 32'(i));
      check($sformatf("hold%0d_opb", i), ex_op_b_o, 32'hBB);
      push_exp(1, 1, 32'h200, 32'h20, 4'd3, 5'd10, 1, 0, 0);
      tick();
      pop_check($sformatf("hold%0d", i));
    end
    hold_i = 0; flush_i = 0; mem_rd_wren_i = 0; id_valid_i = 0;

    // Asynchronous reset mid-cycle with a valid instruction in EX
    #2;
    check("pre_rst_valid", 32'(ex_valid_o), 32'h1);
    rst_ni = 0;
    #1;
    check_all_zero("async_rst");
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
